// File: rtl/cms_trace_engine.sv
// Trace packetiser: samples the committed PC/instruction stream, applies trigger and address-window
// filtering, and queues {instr, ts_delta, pc, event counts} packets for an AXI-Stream consumer.
module cms_trace_engine #(
    parameter int XLEN       = 64,
    parameter int INSTR_W    = 32,
    parameter int NUM_EVENTS = 8,
    parameter int EVT_CNT_W  = 8,
    parameter int TS_W       = 64,
    parameter int NUM_RANGES = 2,
    parameter int FIFO_DEPTH = 16,
    localparam int PKT_W     = INSTR_W + TS_W + XLEN + NUM_EVENTS * EVT_CNT_W
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic                          pc_valid,
    input  logic [XLEN-1:0]               pc,
    input  logic [INSTR_W-1:0]            instr,
    input  logic [NUM_EVENTS-1:0]         perf_events,
    input  logic                          ctrl_we,
    input  logic [7:0]                    ctrl_addr,
    input  logic [63:0]                   ctrl_wdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic [PKT_W-1:0]              m_axis_tdata,
    output logic                          m_axis_tlast,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [31:0]                   dropped_count,
    output logic [1:0]                    trace_state
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [INSTR_W-1:0] WFI_INSTR = INSTR_W'(32'h1050_0073);

    typedef enum logic [1:0] {
        ST_WAIT  = 2'd0,
        ST_TRACE = 2'd1,
        ST_STOP  = 2'd2
    } state_e;

    // Stream and control writes share one input stage, so a write only affects later samples.
    logic                  s_act_q;
    logic [XLEN-1:0]       s_pc_q;
    logic [INSTR_W-1:0]    s_instr_q;
    logic [NUM_EVENTS-1:0] s_ev_q;
    logic [TS_W-1:0]       s_ts_q;
    logic                  s_we_q;
    logic [7:0]            s_addr_q;
    logic [63:0]           s_wdata_q;
    logic [TS_W-1:0]       ts_q;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
        if (rst) begin
            s_act_q   <= 1'b0;
            s_pc_q    <= '0;
            s_instr_q <= '0;
            s_ev_q    <= '0;
            s_ts_q    <= '0;
            s_we_q    <= 1'b0;
            s_addr_q  <= '0;
            s_wdata_q <= '0;
            ts_q      <= '0;
        end else begin
            s_act_q   <= pc_valid & en;
            s_pc_q    <= pc;
            s_instr_q <= instr;
            s_ev_q    <= perf_events;
            s_ts_q    <= ts_q;
            s_we_q    <= ctrl_we;
            s_addr_q  <= ctrl_addr;
            s_wdata_q <= ctrl_wdata;
            ts_q      <= ts_q + TS_W'(1);
        end
    end

    logic                  start_en_q;
    logic                  end_en_q;
    logic [XLEN-1:0]       start_addr_q;
    logic [XLEN-1:0]       end_addr_q;
    logic [31:0]           tlast_int_q;
    logic [NUM_RANGES-1:0] range_en_q;
    logic [XLEN-1:0]       range_lo_q [NUM_RANGES];
    logic [XLEN-1:0]       range_hi_q [NUM_RANGES];
    logic [XLEN-1:0]       wdata_x;
    logic                  rearm;
    logic                  clear_drop;

    assign wdata_x    = XLEN'(s_wdata_q);
    assign rearm      = s_we_q && (s_addr_q == 8'd5);
    assign clear_drop = s_we_q && (s_addr_q == 8'd6);

    always_ff @(posedge clk) begin
        if (rst) begin
            start_en_q   <= 1'b0;
            end_en_q     <= 1'b0;
            start_addr_q <= '0;
            end_addr_q   <= '0;
            tlast_int_q  <= '0;
            range_en_q   <= '0;
            for (int i = 0; i < NUM_RANGES; i++) begin
                range_lo_q[i] <= '0;
                range_hi_q[i] <= '1;
            end
        end else if (s_we_q) begin
            case (s_addr_q)
                8'd0:    start_en_q   <= s_wdata_q[0];
                8'd1:    end_en_q     <= s_wdata_q[0];
                8'd2:    start_addr_q <= wdata_x;
                8'd3:    end_addr_q   <= wdata_x;
                8'd4:    tlast_int_q  <= s_wdata_q[31:0];
                8'd7:    range_en_q   <= s_wdata_q[NUM_RANGES-1:0];
                default: begin
                    for (int i = 0; i < NUM_RANGES; i++) begin
                        if (s_addr_q == 8'(8 + 2 * i)) range_lo_q[i] <= wdata_x;
                        if (s_addr_q == 8'(9 + 2 * i)) range_hi_q[i] <= wdata_x;
                    end
                end
            endcase
        end
    end

    logic range_ok;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        range_ok = (range_en_q == '0);
        for (int i = 0; i < NUM_RANGES; i++) begin
            if (range_en_q[i] && s_pc_q >= range_lo_q[i] && s_pc_q <= range_hi_q[i]) range_ok = 1'b1;
        end
    end

    state_e state_q, state_d;
    logic   start_hit;
    logic   is_wfi;
    logic   start_match;

    assign is_wfi      = (s_instr_q == WFI_INSTR);
    assign start_match = (s_pc_q == start_addr_q);

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_TRACE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        start_hit = 1'b0;
        if (s_act_q) begin
            case (state_q)
                ST_WAIT: if (start_match) begin
                    state_d   = ST_TRACE;
                    start_hit = 1'b1;
                end
                ST_TRACE: if ((end_en_q && s_pc_q == end_addr_q) || is_wfi) state_d = ST_STOP;
                ST_STOP: if (start_en_q && start_match) begin
                    state_d   = ST_TRACE;
                    start_hit = 1'b1;
                end
                default: state_d = ST_TRACE;
            endcase
        end
        if (rearm) state_d = start_en_q ? ST_WAIT : ST_TRACE;
    end

    assign trace_state = state_q;

    logic emit;
    logic push;
    logic pop;
    logic drop;
    logic fifo_full;
    logic fifo_empty;

    assign emit = s_act_q && (state_q == ST_TRACE || start_hit) && range_ok;

    // A counter restarts from the push-cycle event bit, so that event lands in the next packet.
    logic [EVT_CNT_W-1:0]            cnt_q [NUM_EVENTS];
    logic [EVT_CNT_W-1:0]            cnt_d [NUM_EVENTS];
    logic [NUM_EVENTS*EVT_CNT_W-1:0] cnt_flat;

    always_comb begin
        for (int i = 0; i < NUM_EVENTS; i++) begin
            cnt_d[i]                         = cnt_q[i];
            cnt_flat[i*EVT_CNT_W +: EVT_CNT_W] = cnt_q[i];
            if (push)                          cnt_d[i] = EVT_CNT_W'(s_ev_q[i]);
            else if (s_ev_q[i] && cnt_q[i] != '1) cnt_d[i] = cnt_q[i] + EVT_CNT_W'(1);
        end
    end

    logic [TS_W-1:0] last_push_ts_q;
    logic [31:0]     tl_cnt_q;
    logic [31:0]     tl_next;
    logic            pkt_last;
    logic [PKT_W-1:0] pkt;

    assign tl_next  = tl_cnt_q + 32'd1;
    assign pkt_last = is_wfi || (tlast_int_q != 32'd0 && tl_next >= tlast_int_q);
    assign pkt      = {s_instr_q, s_ts_q - last_push_ts_q, s_pc_q, cnt_flat};

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_EVENTS; i++) cnt_q[i] <= '0;
            last_push_ts_q <= '0;
            tl_cnt_q       <= '0;
        end else begin
            for (int i = 0; i < NUM_EVENTS; i++) cnt_q[i] <= cnt_d[i];
            if (push) begin
                last_push_ts_q <= s_ts_q;
                tl_cnt_q       <= pkt_last ? 32'd0 : tl_next;
            end
        end
    end

    logic [PKT_W:0]  fifo_mem_q [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   rd_ptr_q;
    logic [AW:0]     count_q;
    logic [31:0]     dropped_q;

    assign fifo_full  = (count_q == (AW+1)'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);
    assign pop        = !fifo_empty && m_axis_tready;
    assign push       = emit && (!fifo_full || pop);
    assign drop       = emit && fifo_full && !pop;

    // NOTE: the storage array has no reset; the pointers and count define which entries are valid.
    always_ff @(posedge clk) begin
        if (push) fifo_mem_q[wr_ptr_q] <= {pkt_last, pkt};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            dropped_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
            if (clear_drop)                 dropped_q <= '0;
            else if (drop && dropped_q != '1) dropped_q <= dropped_q + 32'd1;
        end
    end

    assign m_axis_tvalid                 = !fifo_empty;
    assign {m_axis_tlast, m_axis_tdata}  = fifo_empty ? '0 : fifo_mem_q[rd_ptr_q];
    assign fifo_level                    = count_q;
    assign dropped_count                 = dropped_q;

endmodule

// File: tb/tb_cms_trace_engine.sv
// Directed bench for cms_trace_engine: emit timing, range filter, triggers, counters, overflow, tlast.
module tb_cms_trace_engine;

    localparam int PKT_W = 32 + 64 + 64 + 64;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic             pc_valid;
    logic [63:0]      pc;
    logic [31:0]      instr;
    logic [7:0]       perf_events;
    logic             ctrl_we;
    logic [7:0]       ctrl_addr;
    logic [63:0]      ctrl_wdata;
    logic             m_axis_tvalid;
    logic             m_axis_tready;
    logic [PKT_W-1:0] m_axis_tdata;
    logic             m_axis_tlast;
    logic [4:0]       fifo_level;
    logic [31:0]      dropped_count;
    logic [1:0]       trace_state;

    int errors = 0;
    int checks = 0;

    logic [PKT_W-1:0] q_data[$];
    logic             q_last[$];

    cms_trace_engine dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .pc_valid      (pc_valid),
        .pc            (pc),
        .instr         (instr),
        .perf_events   (perf_events),
        .ctrl_we       (ctrl_we),
        .ctrl_addr     (ctrl_addr),
        .ctrl_wdata    (ctrl_wdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tlast  (m_axis_tlast),
        .fifo_level    (fifo_level),
        .dropped_count (dropped_count),
        .trace_state   (trace_state)
    );

    always #5 clk = ~clk;

    // Inputs change 1 time unit after the falling edge; the monitor looks 2 units after it.
    always @(negedge clk) begin
        #2;
        if (!rst && m_axis_tvalid && m_axis_tready) begin
            q_data.push_back(m_axis_tdata);
            q_last.push_back(m_axis_tlast);
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b1; pc_valid = 1'b0; pc = '0; instr = '0; perf_events = '0;
        ctrl_we = 1'b0; ctrl_addr = '0; ctrl_wdata = '0; m_axis_tready = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        q_data.delete();
        q_last.delete();
    endtask

    task automatic sample(input logic [63:0] p, input logic [31:0] ins, input logic [7:0] ev);
        pc_valid = 1'b1; pc = p; instr = ins; perf_events = ev;
        step();
        pc_valid = 1'b0; perf_events = '0;
    endtask

    task automatic wr(input logic [7:0] a, input logic [63:0] d);
        ctrl_we = 1'b1; ctrl_addr = a; ctrl_wdata = d;
        step();
        ctrl_we = 1'b0;
    endtask

    function automatic logic [63:0] f_pc(input logic [PKT_W-1:0] p);
        return p[127:64];
    endfunction

    function automatic logic [63:0] f_delta(input logic [PKT_W-1:0] p);
        return p[191:128];
    endfunction

    task automatic test_reset();
        do_reset();
        checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid got=%b exp=0", m_axis_tvalid); end
        checks++; if (m_axis_tlast !== 1'b0) begin errors++; $display("FAIL reset_tlast got=%b exp=0", m_axis_tlast); end
        checks++; if (m_axis_tdata !== '0) begin errors++; $display("FAIL reset_tdata got=%h exp=0", m_axis_tdata); end
        checks++; if (fifo_level !== 5'd0) begin errors++; $display("FAIL reset_level got=%0d exp=0", fifo_level); end
        checks++; if (dropped_count !== 32'd0) begin errors++; $display("FAIL reset_dropped got=%0d exp=0", dropped_count); end
        checks++; if (trace_state !== 2'd1) begin errors++; $display("FAIL reset_state got=%0d exp=1", trace_state); end
    endtask

    task automatic test_basic_emit();
        logic [63:0] exp_pc [3];
        logic [63:0] exp_dt [3];
        exp_pc[0] = 64'h1000; exp_pc[1] = 64'h1004; exp_pc[2] = 64'h1008;
        exp_dt[0] = 64'd5;    exp_dt[1] = 64'd10;   exp_dt[2] = 64'd10;
        do_reset();
        repeat (5) step();
        sample(64'h1000, 32'h0000_0013, 8'h00);
        checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL basic_tvalid_t1 got=%b exp=0", m_axis_tvalid); end
        step();
        checks++; if (m_axis_tvalid !== 1'b1) begin errors++; $display("FAIL basic_tvalid_t2 got=%b exp=1", m_axis_tvalid); end
        repeat (8) step();
        sample(64'h1004, 32'h0000_0013, 8'h00);
        repeat (9) step();
        sample(64'h1008, 32'h0000_0013, 8'h00);
        repeat (5) step();
        checks++; if (q_data.size() !== 3) begin errors++; $display("FAIL basic_count got=%0d exp=3", q_data.size()); end
        for (int i = 0; i < 3 && i < q_data.size(); i++) begin
            checks++;
            if (f_pc(q_data[i]) !== exp_pc[i] || f_delta(q_data[i]) !== exp_dt[i] || q_last[i] !== 1'b0) begin
                errors++;
                $display("FAIL basic_pkt%0d got pc=%h dt=%0d last=%b exp pc=%h dt=%0d last=0",
                         i, f_pc(q_data[i]), f_delta(q_data[i]), q_last[i], exp_pc[i], exp_dt[i]);
            end
        end
    endtask

    task automatic test_range();
        do_reset();
        wr(8'd7, 64'h1);
        wr(8'd8, 64'h2000);
        wr(8'd9, 64'h20FF);
        sample(64'h1FFC, 32'h13, 8'h0);
        sample(64'h2000, 32'h13, 8'h0);
        sample(64'h20FF, 32'h13, 8'h0);
        sample(64'h2100, 32'h13, 8'h0);
        repeat (5) step();
        checks++; if (q_data.size() !== 2) begin errors++; $display("FAIL range_count got=%0d exp=2", q_data.size()); end
        if (q_data.size() >= 2) begin
            checks++; if (f_pc(q_data[0]) !== 64'h2000) begin errors++; $display("FAIL range_pkt0 got=%h exp=2000", f_pc(q_data[0])); end
            checks++; if (f_pc(q_data[1]) !== 64'h20FF) begin errors++; $display("FAIL range_pkt1 got=%h exp=20ff", f_pc(q_data[1])); end
        end
    endtask

    task automatic test_triggers();
        do_reset();
        wr(8'd0, 64'h1);
        wr(8'd2, 64'h3000);
        wr(8'd1, 64'h1);
        wr(8'd3, 64'h3010);
        wr(8'd5, 64'h0);
        repeat (3) step();
        checks++; if (trace_state !== 2'd0) begin errors++; $display("FAIL trig_rearm_state got=%0d exp=0", trace_state); end
        for (int i = 0; i < 13; i++) sample(64'h2FF0 + 64'(4 * i), 32'h13, 8'h0);
        repeat (5) step();
        checks++; if (q_data.size() !== 5) begin errors++; $display("FAIL trig_count got=%0d exp=5", q_data.size()); end
        for (int i = 0; i < 5 && i < q_data.size(); i++) begin
            checks++;
            if (f_pc(q_data[i]) !== 64'h3000 + 64'(4 * i)) begin
                errors++; $display("FAIL trig_pkt%0d got=%h exp=%h", i, f_pc(q_data[i]), 64'h3000 + 64'(4 * i));
            end
        end
        checks++; if (trace_state !== 2'd2) begin errors++; $display("FAIL trig_end_state got=%0d exp=2", trace_state); end
    endtask

    task automatic test_counter_saturation();
        do_reset();
        perf_events = 8'h01;
        repeat (300) step();
        sample(64'h5000, 32'h13, 8'h00);
        perf_events = 8'h09;
        repeat (5) step();
        sample(64'h5004, 32'h13, 8'h02);
        sample(64'h5008, 32'h13, 8'h00);
        repeat (5) step();
        checks++; if (q_data.size() !== 3) begin errors++; $display("FAIL sat_count got=%0d exp=3", q_data.size()); end
        if (q_data.size() >= 3) begin
            checks++; if (q_data[0][63:0] !== 64'h0000_0000_0000_00FF) begin errors++; $display("FAIL sat_pkt0_cnt got=%h exp=ff", q_data[0][63:0]); end
            checks++; if (q_data[1][63:0] !== 64'h0000_0000_0500_0005) begin errors++; $display("FAIL sat_pkt1_cnt got=%h exp=0500_0005", q_data[1][63:0]); end
            checks++; if (q_data[2][63:0] !== 64'h0000_0000_0000_0100) begin errors++; $display("FAIL sat_pkt2_cnt got=%h exp=0100", q_data[2][63:0]); end
        end
    endtask

    task automatic test_overflow();
        logic [PKT_W-1:0] held;
        do_reset();
        m_axis_tready = 1'b0;
        for (int i = 0; i < 20; i++) sample(64'h4000 + 64'(4 * i), 32'h13, 8'h0);
        repeat (4) step();
        checks++; if (fifo_level !== 5'd16) begin errors++; $display("FAIL ovf_level got=%0d exp=16", fifo_level); end
        checks++; if (dropped_count !== 32'd4) begin errors++; $display("FAIL ovf_dropped got=%0d exp=4", dropped_count); end
        checks++; if (m_axis_tvalid !== 1'b1 || f_pc(m_axis_tdata) !== 64'h4000) begin
            errors++; $display("FAIL ovf_head got valid=%b pc=%h exp valid=1 pc=4000", m_axis_tvalid, f_pc(m_axis_tdata));
        end
        held = m_axis_tdata;
        step();
        checks++; if (m_axis_tdata !== held) begin errors++; $display("FAIL ovf_stall_stable got=%h exp=%h", m_axis_tdata, held); end
        m_axis_tready = 1'b1;
        repeat (20) step();
        checks++; if (q_data.size() !== 16) begin errors++; $display("FAIL ovf_drain_count got=%0d exp=16", q_data.size()); end
        for (int i = 0; i < 16 && i < q_data.size(); i++) begin
            checks++;
            if (f_pc(q_data[i]) !== 64'h4000 + 64'(4 * i)) begin
                errors++; $display("FAIL ovf_pkt%0d got=%h exp=%h", i, f_pc(q_data[i]), 64'h4000 + 64'(4 * i));
            end
        end
        if (q_data.size() >= 2) begin
            checks++; if (f_delta(q_data[1]) !== 64'd1) begin errors++; $display("FAIL ovf_delta got=%0d exp=1", f_delta(q_data[1])); end
        end
        checks++; if (fifo_level !== 5'd0) begin errors++; $display("FAIL ovf_level_after got=%0d exp=0", fifo_level); end
        wr(8'd6, 64'h0);
        repeat (2) step();
        checks++; if (dropped_count !== 32'd0) begin errors++; $display("FAIL ovf_clear got=%0d exp=0", dropped_count); end
    endtask

    task automatic test_tlast();
        logic [6:0] exp_last;
        exp_last = 7'b110_0100;
        do_reset();
        wr(8'd4, 64'd3);
        for (int i = 0; i < 6; i++) sample(64'h7000 + 64'(4 * i), 32'h13, 8'h0);
        sample(64'h7018, 32'h1050_0073, 8'h0);
        repeat (5) step();
        checks++; if (q_last.size() !== 7) begin errors++; $display("FAIL tlast_count got=%0d exp=7", q_last.size()); end
        for (int i = 0; i < 7 && i < q_last.size(); i++) begin
            checks++;
            if (q_last[i] !== exp_last[i]) begin errors++; $display("FAIL tlast_pkt%0d got=%b exp=%b", i, q_last[i], exp_last[i]); end
        end
        checks++; if (trace_state !== 2'd2) begin errors++; $display("FAIL tlast_state got=%0d exp=2", trace_state); end
    endtask

    task automatic test_en_low();
        do_reset();
        en = 1'b0;
        for (int i = 0; i < 4; i++) sample(64'h6000, 32'h1050_0073, 8'h01);
        en = 1'b1;
        sample(64'h6004, 32'h13, 8'h00);
        repeat (5) step();
        checks++; if (q_data.size() !== 1) begin errors++; $display("FAIL en_count got=%0d exp=1", q_data.size()); end
        if (q_data.size() >= 1) begin
            checks++; if (f_pc(q_data[0]) !== 64'h6004 || q_data[0][63:0] !== 64'h4) begin
                errors++; $display("FAIL en_pkt got pc=%h cnt=%h exp pc=6004 cnt=4", f_pc(q_data[0]), q_data[0][63:0]);
            end
        end
        checks++; if (trace_state !== 2'd1) begin errors++; $display("FAIL en_state got=%0d exp=1", trace_state); end
    endtask

    task automatic test_mid_reset();
        do_reset();
        m_axis_tready = 1'b0;
        for (int i = 0; i < 3; i++) sample(64'h8000 + 64'(4 * i), 32'h13, 8'h0);
        repeat (3) step();
        checks++; if (fifo_level !== 5'd3) begin errors++; $display("FAIL midrst_level_before got=%0d exp=3", fifo_level); end
        do_reset();
        checks++; if (fifo_level !== 5'd0 || m_axis_tvalid !== 1'b0 || m_axis_tdata !== '0) begin
            errors++; $display("FAIL midrst_flush got level=%0d valid=%b exp level=0 valid=0 data=0", fifo_level, m_axis_tvalid);
        end
    endtask

    initial begin
        test_reset();
        test_basic_emit();
        test_range();
        test_triggers();
        test_counter_saturation();
        test_overflow();
        test_tlast();
        test_en_low();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cms_trace_engine.md
# cms_trace_engine

Parametrised next-generation trace packetiser for the continuous monitoring system. It samples the committed PC/instruction stream, applies start/end triggers and up to NUM_RANGES address windows, and attaches per-event saturating counters and a timestamp delta to each packet. Packets are buffered in an internal FIFO and sent to the AXI-Stream DMA path, with drop accounting on overflow.

## Interface
- XLEN, 64, PC width
- INSTR_W, 32, instruction width
- NUM_EVENTS, 8, performance event inputs (1..128)
- EVT_CNT_W, 8, per-event counter width
- TS_W, 64, timestamp width
- NUM_RANGES, 2, address windows (1..8)
- FIFO_DEPTH, 16, packet FIFO depth (power of 2, ≥2)
- PKT_W, derived: INSTR_W+TS_W+XLEN+NUM_EVENTS*EVT_CNT_W
---
- Clocking and reset (already decided): one clock; reset is synchronous and active-high.
- clk  in  1  sole clock
- rst  in  1  synchronous active-high reset
- en  in  1  emission enable
- pc_valid  in  1  pc/instr commit this cycle
- pc  in  XLEN  committed PC
- instr  in  INSTR_W  committed instruction
- perf_events  in  NUM_EVENTS  event bitmap for this cycle
- ctrl_we  in  1  level write strobe, one write per high cycle
- ctrl_addr  in  8  register index
- ctrl_wdata  in  64  write data, truncated to the target width
- m_axis_tvalid  out  1
- m_axis_tready  in  1
- m_axis_tdata  out  PKT_W  {instr, ts_delta, pc, cnt[NUM_EVENTS-1]..cnt[0]}
- m_axis_tlast  out  1
- fifo_level  out  $clog2(FIFO_DEPTH)+1  occupancy
- dropped_count  out  32  saturating count of dropped packets
- trace_state  out  2  0=WAIT_START, 1=TRACING, 2=STOPPED

## Operation
- Control registers (all reset to 0 except noted):
  - 0 START_EN
  - 1 END_EN
  - 2 START_ADDR
  - 3 END_ADDR
  - 4 TLAST_INTERVAL (0 = disabled)
  - 5 REARM (write-action)
  - 6 CLEAR_DROPPED (write-action)
  - 7 RANGE_EN bitmap
  - 8+2i RANGE_LO[i]
  - 9+2i RANGE_HI[i], reset all-ones
  - Other addresses are ignored.
- FSM, evaluated only on cycles with pc_valid & en:
  - WAIT_START → TRACING when pc==START_ADDR.
  - TRACING → STOPPED when END_EN & pc==END_ADDR. The end instruction is still emitted.
  - TRACING → STOPPED when instr==0x10500073 (wfi). That packet is emitted with tlast=1.
  - STOPPED → TRACING when START_EN & pc==START_ADDR.
  - A REARM write sets WAIT_START if START_EN, else TRACING. It overrides any trigger transition in the same cycle.
  - Reset state: TRACING.
- Emit condition: pc_valid & en & (state==TRACING, or a start match this cycle) & range_ok.
  - range_ok = (RANGE_EN==0) or pc lies in some enabled window, LO ≤ pc ≤ HI inclusive, unsigned.
- Counters:
  - Each event counter increments when its bit is high and saturates at all-ones.
  - On a successful FIFO push, every counter loads its current event bit (0 or 1), so the current-cycle event goes to the next packet.
  - The packet carries counts up to and excluding the emit cycle.
- Timestamp:
  - ts is free-running from 0 after reset.
  - ts_delta = ts − last_push_ts, modulo 2^TS_W. last_push_ts is updated on push.
- Overflow: if emit occurs when the FIFO is full and no pop happens that cycle, the packet is dropped.
  - Counters and last_push_ts are not reset.
  - dropped_count increments, saturating at 2^32−1. CLEAR_DROPPED zeroes it.
- tlast:
  - tlast=1 if the packet is wfi, or if the pushed-packet count since the last tlast reaches TLAST_INTERVAL.
  - The interval count resets on any tlast.
  - tlast is stored in the FIFO with the data.
- en low: no emits and the FSM is frozen; counters and ts keep running.

## Timing
- Inputs are registered at cycle t and the FIFO write happens at t+1.
- m_axis_tvalid rises at t+2 if the FIFO was empty.
- Pop when tvalid & tready. A push into a full FIFO succeeds if a pop occurs in the same cycle.
- tdata and tlast are stable while tvalid & ~tready.
- A ctrl write at cycle t takes effect at t+1. Filtering at cycle t uses the old values.
- fifo_level updates the cycle after a push or pop. A simultaneous push and pop leaves it unchanged.
- Reset values:
  - tvalid=0, tlast=0, tdata=0
  - fifo_level=0, dropped_count=0
  - trace_state=1
  - all counters, ts and last_push_ts = 0
- Reset mid-stream flushes the FIFO with no partial packet.

## Test plan
- **Basic emit:** after reset, tready=1, pc_valid pulses with pc 0x1000/0x1004/0x1008 spaced 10 cycles apart → three packets; first ts_delta equals the sample cycle index, later deltas are 10.
- **Range filter:** RANGE_EN=1, LO[0]=0x2000, HI[0]=0x20FF; pcs 0x1FFC, 0x2000, 0x20FF, 0x2100 → only 0x2000 and 0x20FF are emitted.
- **Triggers:** START_EN=1, REARM, START_ADDR=0x3000, END_EN=1, END_ADDR=0x3010; stream 0x2FF0..0x3020 step 4 → packets 0x3000..0x3010 only; trace_state ends at 2.
- **Counter saturation:** EVT_CNT_W=8, event 0 high for 300 cycles before an emit → cnt[0]=255; the next packet carries the count of subsequent events.
- **Overflow:** tready=0, 20 emits with FIFO_DEPTH=16 → fifo_level=16, dropped_count=4; then tready=1 → 16 packets drain in order.
- **tlast:** TLAST_INTERVAL=3 over 7 emits, the 7th being wfi → tlast on packets 3, 6 and 7; trace_state=2 afterwards.
